// File: rtl/imem_pkg.sv
// imem_pkg -- shared definitions for the instruction-memory fetch block.
//   NOP_INSTR_DEFAULT : word returned for a faulting fetch (RV32I "addi x0,x0,0")
//   OCC_W / occ_t     : response-FIFO occupancy type (0..2 entries)
//   rsp_t             : one response-FIFO entry, {instr, fault} = 33 bits
//   sat_inc16()       : 16-bit saturating increment for the statistics counters
package imem_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam int OCC_W = 2;
    typedef logic [OCC_W-1:0] occ_t;
    localparam occ_t OCC_FULL = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo -- two-entry response FIFO between the fetch stage and the
// response channel.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write one {instr, fault} entry (ignored when full)
//   pop          : remove the head entry (ignored when empty)
//   valid, head  : head entry present / its contents
//   count        : current occupancy, 0..2
module imem_rsp_fifo
    import imem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  rsp_t wdata,
    input  logic pop,
    output logic valid,
    output rsp_t head,
    output occ_t count
);

    rsp_t entry [2];
    logic wptr;
    logic rptr;
    occ_t occ;
    logic do_push;
    logic do_pop;

    assign do_push = push && (occ != OCC_FULL);
    assign do_pop  = pop && (occ != '0);

    // NOTE: the two entries are reset so the response outputs read zero during
    // reset; the cost is a handful of flops, unlike the instruction storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) entry[i] <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= '0;
        end else begin
            if (do_push) begin
                entry[wptr] <= wdata;
                wptr        <= ~wptr;   // one-bit pointers wrap modulo 2
            end
            if (do_pop) rptr <= ~rptr;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;    // push+pop together leaves occupancy as is
            endcase
        end
    end

    // A push never targets the head slot while an entry is waiting, so the
    // head stays stable until it is popped.
    assign head  = entry[rptr];
    assign valid = (occ != '0);
    assign count = occ;

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch -- word-addressed instruction memory with a valid/ready fetch
// port, a program-load write port and saturating statistics.
//   clk, reset_n                   : clock, asynchronous active-low reset
//   load_en, load_addr, load_data  : program-load write (byte address, word data)
//   req_valid, req_ready, req_addr : fetch request channel (byte address)
//   rsp_valid, rsp_ready,
//   rsp_instr, rsp_fault           : fetch response channel, latency 1
//   fetch_cnt, fault_cnt           : accepted / faulting request counts, saturating
module imem_fetch
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 8,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter              INIT_FILE = ""
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_instr,
    output logic          rsp_fault,
    output logic [15:0]   fetch_cnt,
    output logic [15:0]   fault_cnt
);

    localparam int IW = AW - 2;           // word-index width carried by an address
    localparam int LW = $clog2(DEPTH);    // word-index width actually stored
    localparam logic [IW:0] DEPTH_EXT = (IW + 1)'(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [IW-1:0] load_idx;
    logic [IW-1:0] req_idx;
    logic          load_ok;
    logic          req_fault;
    logic          accept;
    rsp_t          fetch_rsp;
    rsp_t          head;
    occ_t          occ;

    assign load_idx = load_addr[AW-1:2];
    assign req_idx  = req_addr[AW-1:2];

    // Unaligned or out-of-range loads are dropped without any indication.
    assign load_ok = load_en && (load_addr[1:0] == 2'b00) && ({1'b0, load_idx} < DEPTH_EXT);

    // NOTE: storage is deliberately left out of reset so it maps onto
    // distributed RAM and keeps its program across a reset.
    always_ff @(posedge clk) begin
        if (load_ok) mem[load_idx[LW-1:0]] <= load_data;
    end

    assign req_fault = (req_addr[1:0] != 2'b00) || !({1'b0, req_idx} < DEPTH_EXT);

    // NOTE: every field gets a value on every path so no latch is inferred.
    always_comb begin
        fetch_rsp.fault = req_fault;
        fetch_rsp.instr = NOP_INSTR;
        if (!req_fault) fetch_rsp.instr = mem[req_idx[LW-1:0]];
    end

    // A load owns the cycle; the request waits so it sees the written word
    // on the following edge.
    assign req_ready = !load_en && (occ != OCC_FULL);
    assign accept    = req_valid && req_ready;

    imem_rsp_fifo u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .wdata   (fetch_rsp),
        .pop     (rsp_ready),
        .valid   (rsp_valid),
        .head    (head),
        .count   (occ)
    );

    assign rsp_instr = head.instr;
    assign rsp_fault = head.fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            fault_cnt <= '0;
        end else if (accept) begin
            fetch_cnt <= sat_inc16(fetch_cnt);
            if (req_fault) fault_cnt <= sat_inc16(fault_cnt);
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch -- self-checking bench for imem_fetch. A queue-based model
// of the memory and the response channel predicts every observed value.
module tb_imem_fetch;

    localparam int          DEPTH = 64;
    localparam int          AW    = 9;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_instr;
    logic          rsp_fault;
    logic [15:0]   fetch_cnt;
    logic [15:0]   fault_cnt;

    imem_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .fetch_cnt (fetch_cnt),
        .fault_cnt (fault_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [32:0] ref_q [$];        // {instr, fault} in request order
    int          ref_fetch = 0;
    int          ref_fault = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_lookup(input int addr);
        if ((addr % 4) != 0 || (addr / 4) >= DEPTH) return {NOP, 1'b1};
        return {ref_mem[addr / 4], 1'b0};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(ref_q.size() > 0));
        if (ref_q.size() > 0) begin
            check({tag, ".rsp_instr"}, rsp_instr, ref_q[0][32:1]);
            check({tag, ".rsp_fault"}, 32'(rsp_fault), 32'(ref_q[0][0]));
        end
        check({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(ref_fetch));
        check({tag, ".fault_cnt"}, 32'(fault_cnt), 32'(ref_fault));
    endtask

    // One clock cycle: inputs were set after the previous falling edge.
    task automatic step(input string tag, input bit chk, output bit acc);
        bit pop;
        bit flt;
        int la;
        int ra;
        #1;
        la  = int'(load_addr);
        ra  = int'(req_addr);
        acc = req_valid && !load_en && (ref_q.size() < 2);
        pop = rsp_ready && (ref_q.size() > 0);
        if (chk) check({tag, ".req_ready"}, 32'(req_ready), 32'(!load_en && (ref_q.size() < 2)));
        @(posedge clk);
        if (pop) void'(ref_q.pop_front());
        if (acc) begin
            ref_q.push_back(ref_lookup(ra));
            flt = ref_q[ref_q.size() - 1][0];
            if (ref_fetch < 65535) ref_fetch++;
            if (flt && ref_fault < 65535) ref_fault++;
        end
        if (load_en && (la % 4) == 0 && (la / 4) < DEPTH) ref_mem[la / 4] = load_data;
        @(negedge clk);
        if (chk) check_outputs(tag);
    endtask

    task automatic idle_inputs();
        load_en   = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit acc;
        idle_inputs();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(tag, 1'b1, acc);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        logic [31:0] w;

        // Reset state.
        #12;
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.rsp_instr", rsp_instr, 32'd0);
        check("reset.rsp_fault", 32'(rsp_fault), 32'd0);
        check("reset.fetch_cnt", 32'(fetch_cnt), 32'd0);
        check("reset.fault_cnt", 32'(fault_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill every word so nothing later reads uninitialised storage.
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i * 4);
            load_data = $urandom;
            step("preload", 1'b1, acc);
        end
        idle_inputs();

        // Load then fetch: response the next cycle.
        load_en = 1'b1; load_addr = 'h04; load_data = 32'h0010_0093;
        step("load4", 1'b1, acc);
        load_en = 1'b0; req_valid = 1'b1; req_addr = 'h04; rsp_ready = 1'b0;
        step("fetch4", 1'b1, acc);
        check("fetch4.instr", rsp_instr, 32'h0010_0093);
        drain("fetch4.drain");

        // Unaligned and out-of-range fetches fault.
        req_valid = 1'b1; req_addr = 'h06; rsp_ready = 1'b1;
        step("fault06", 1'b1, acc);
        req_addr = 'h100;
        step("fault100", 1'b1, acc);
        check("fault100.instr", rsp_instr, NOP);
        drain("fault.drain");
        check("fault.count", 32'(fault_cnt), 32'd2);

        // Back-pressure: two accepted, third waits until the head is popped.
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 'h10; step("bp0", 1'b1, acc);
        req_addr = 'h14; step("bp1", 1'b1, acc);
        req_addr = 'h18; step("bp2", 1'b1, acc);
        check("bp2.accepted", 32'(acc), 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4 && !acc; i++) step("bp.release", 1'b1, acc);
        check("bp.third_accepted", 32'(acc), 32'd1);
        drain("bp.drain");

        // Load and request together: load wins, request sees the new word next.
        load_en = 1'b1; load_addr = 'h08; load_data = 32'hCAFE_F00D;
        req_valid = 1'b1; req_addr = 'h08; rsp_ready = 1'b0;
        step("ldreq", 1'b1, acc);
        check("ldreq.blocked", 32'(acc), 32'd0);
        load_en = 1'b0;
        step("ldreq.fetch", 1'b1, acc);
        check("ldreq.new_word", rsp_instr, 32'hCAFE_F00D);
        drain("ldreq.drain");

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            load_en   = ($urandom_range(0, 7) == 0);
            load_addr = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, DEPTH - 1) * 4)
                                                    : AW'($urandom);
            load_data = $urandom;
            req_valid = ($urandom_range(0, 9) < 6);
            req_addr  = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, DEPTH - 1) * 4)
                                                    : AW'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            step("rand", 1'b1, acc);
        end
        drain("rand.drain");

        // Reset with the FIFO full: everything cleared at once, storage kept.
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 'h20; step("rst.fill0", 1'b1, acc);
        req_addr = 'h24; step("rst.fill1", 1'b1, acc);
        idle_inputs();
        w = ref_mem[9];
        #2 reset_n = 1'b0;
        #1;
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_instr", rsp_instr, 32'd0);
        check("rst.rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst.fetch_cnt", 32'(fetch_cnt), 32'd0);
        check("rst.fault_cnt", 32'(fault_cnt), 32'd0);
        ref_q.delete();
        ref_fetch = 0;
        ref_fault = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = 1'b1; req_addr = 'h24; rsp_ready = 1'b1;
        step("rst.readback", 1'b1, acc);
        check("rst.readback.accepted", 32'(acc), 32'd1);
        check("rst.persist", rsp_instr, w);
        for (int i = 0; i < DEPTH; i++) begin
            req_addr = AW'(i * 4);
            step("rst.sweep", 1'b1, acc);
        end
        drain("rst.drain");

        // Saturation of fetch_cnt.
        req_valid = 1'b1; req_addr = 'h0C; rsp_ready = 1'b1;
        for (int i = 0; i < 65540; i++) step("sat", 1'b0, acc);
        step("sat.final", 1'b1, acc);
        check("sat.fetch_cnt", 32'(fetch_cnt), 32'h0000_FFFF);
        drain("sat.drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
